instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries and in-flight request limit; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port redirect_valid, input, 1: branch/jump redirect from decode/execute.
REQ-006 The block SHALL have port redirect_addr, input, 32: redirect target.
REQ-007 The block SHALL have port imem_req_valid, output, 1: instruction memory request valid.
REQ-008 The block SHALL have port imem_req_ready, input, 1: memory accepts request.
REQ-009 The block SHALL have port imem_req_addr, output, 32: word-aligned fetch address.
REQ-010 The block SHALL have port imem_rsp_valid, input, 1: read data valid; responses arrive in order, at least 1 cycle after acceptance.
REQ-011 The block SHALL have port imem_rsp_data, input, 32: fetched instruction.
REQ-012 The block SHALL have port inst_valid, output, 1: instruction available to the decode stage.
REQ-013 The block SHALL have port inst_ready, input, 1: decode accepts instruction.
REQ-014 The block SHALL have port inst_data, output, 32: instruction word.
REQ-015 The block SHALL have port inst_pc, output, 32: address of inst_data.

Function
REQ-016 A request SHALL be accepted when imem_req_valid and imem_req_ready are both high; fetch_pc SHALL then advance by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-017 imem_req_valid SHALL be high only when fifo_count + inflight < FIFO_DEPTH and redirect_valid is low; this credit rule guarantees every response a buffer slot.
REQ-018 Once imem_req_valid is asserted, imem_req_addr SHALL stay stable until acceptance or redirect.
REQ-019 inflight SHALL increment on acceptance, decrement on imem_rsp_valid, and be unchanged when both occur in the same cycle.
REQ-020 A non-dropped response SHALL be pushed to the FIFO with inst_pc taken from rsp_pc; rsp_pc SHALL then increment by 4 with wrap.
REQ-021 inst_valid SHALL equal FIFO non-empty; an entry SHALL pop when inst_valid and inst_ready are both high.
REQ-022 Push and pop in the same cycle SHALL leave the count unchanged; inst_data and inst_pc SHALL hold while inst_valid is high and inst_ready is low.
REQ-023 When redirect_valid is high, the FIFO SHALL be flushed at the next edge; fetch_pc and rsp_pc SHALL be loaded with {redirect_addr[31:2], 2'b00}, and drop_cnt SHALL be loaded with inflight minus any response arriving in that cycle.
REQ-024 A pop completing in the redirect cycle SHALL count as consumed.
REQ-025 A response arriving in the redirect cycle SHALL be discarded.
REQ-026 While drop_cnt > 0, responses SHALL be discarded and SHALL decrement drop_cnt; imem_req_valid SHALL still follow REQ-017 with inflight including dropped responses.
REQ-027 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-028 There SHALL be no combinational path from imem_rsp_* to inst_* outputs; a response is visible on inst_valid no earlier than the cycle after it arrives.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL clear the FIFO, inflight and drop_cnt, and SHALL load fetch_pc and rsp_pc with RESET_PC.
REQ-030 While rst is high, imem_req_valid and inst_valid SHALL be 0, and inst_data and inst_pc SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL abandon outstanding requests; the memory shall be reset together with this block.
REQ-032 The first request SHALL be driven with address RESET_PC in the first cycle after rst is low.

Structure
REQ-033 Package riscv_fetch_pkg SHALL hold XLEN=32, INST_BYTES=4 and the RESET_PC default constant.
REQ-034 One sub-module SHALL exist: fetch_fifo, a synchronous FIFO of {pc, instr}, 64 bits wide, with flush, push, pop, count and empty.

Verification
REQ-035 Release reset, imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> inst_pc sequence is 0x0, 0x4, 0x8, ... with one instruction per cycle from the third cycle onward.
REQ-036 Hold inst_ready=0 -> at most 2 requests are accepted, inst_valid=1 holds the pc 0x0 entry steady, and imem_req_valid=0 until a pop.
REQ-037 Two requests in flight, then redirect_valid with redirect_addr=0x0000_0103 -> both responses are dropped, and the next inst_pc is 0x0000_0100 with the data returned for address 0x100.
REQ-038 Redirect to 0xFFFF_FFF8 -> inst_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 imem_req_ready toggling randomly with 1-3 cycle latency over 1000 cycles -> no FIFO overflow, and inst_pc is strictly sequential except at redirects.
REQ-040 rst pulsed while 2 requests are in flight -> outputs are 0 during reset, and the first post-reset request has address RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types and constants.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package riscv_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction: the address it was fetched from and its word
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^XLEN
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INST_BYTES);
    endfunction

    // Force an address onto an instruction-word boundary
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries feeding the decode stage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full, pop when empty; upstream credits keep push off a full FIFO.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] count,
    output logic          empty
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Pointers and occupancy; a flush discards every entry, including one being pushed
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage array; not reset because the head is only consumed while non-empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word-aligned reads, buffers in-order responses, handles redirects.
// Latency: request in cycle N, response in N+1 or later, instruction on inst_* the cycle after the response.
// Backpressure: requests are credit-limited by FIFO occupancy plus in-flight reads; inst_* holds until inst_ready.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    // Counters hold 0..FIFO_DEPTH; their sum needs one more bit
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            credit_ok;
    logic            req_acc;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_in;
    fetch_entry_t    fifo_head;
    logic [XLEN-1:0] redirect_pc;

    assign redirect_pc = pc_align(redirect_addr);

    // Request side: only issue when every outstanding read is guaranteed a buffer slot
    always_comb begin
        credit_ok      = (SW'(fifo_count) + SW'(inflight_q)) < SW'(FIFO_DEPTH);
        imem_req_valid = ~rst & ~redirect_valid & credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_acc        = imem_req_valid & imem_req_ready;
    end

    // Response side: responses to pre-redirect requests are thrown away, the rest are buffered
    always_comb begin
        rsp_drop      = redirect_valid | (drop_cnt_q != '0);
        fifo_push     = imem_rsp_valid & ~rsp_drop;
        fifo_in.pc    = rsp_pc_q;
        fifo_in.instr = imem_rsp_data;
        fifo_pop      = inst_valid & inst_ready;
    end

    // Decode-side view of the buffer head, forced to zero in reset and when empty
    always_comb begin
        inst_valid = ~rst & ~fifo_empty;
        inst_data  = inst_valid ? fifo_head.instr : '0;
        inst_pc    = inst_valid ? fifo_head.pc    : '0;
    end

    // Next-state for the fetch/response address trackers and the outstanding-read counters
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        // Dropped responses still retire a credit, so inflight always counts every open read
        inflight_d = inflight_q + CW'(req_acc) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            // A response landing this cycle is already discarded, so it is not re-counted
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_acc) begin
                fetch_pc_d = pc_next(fetch_pc_q);
            end
            if (fifo_push) begin
                rsp_pc_d = pc_next(rsp_pc_q);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // State registers; reset abandons any reads still outstanding in memory
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model plus in-order memory model.
// Latency: memory answers 1..3 cycles after acceptance, strictly in order.
// Backpressure: imem_req_ready and inst_ready are driven per scenario, randomly in the soak phase.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // memory model
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          acc_cnt  = 0;

    // reference model of the fetch unit
    logic [31:0] m_fetch;
    logic [31:0] m_rsp_pc;
    int          m_infl;
    int          m_drop;
    logic [63:0] m_fifo[$];

    // delivered instruction log and stream checker
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_dat[$];
    int          dlv_cyc[$];
    logic [31:0] seq_expect = RST_PC;

    // last sampled outputs
    logic        last_req_vld;
    logic [31:0] last_req_addr;
    logic        last_ival;
    logic [31:0] last_ipc;
    logic [31:0] last_idat;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a ^ 32'h5A3C_0F96) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // check that the idx-th delivery after mark has the given pc (and matching memory data)
    task automatic chk_dlv(input string name, input int idx, input logic [31:0] exp_pc);
        if (dlv_pc.size() > idx) begin
            chk(name, dlv_pc[idx], exp_pc);
            chk({name, "_data"}, dlv_dat[idx], mem_fn(exp_pc));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: delivery %0d never happened, required pc %h", name, idx, exp_pc);
        end
    endtask

    // one clock cycle: drive inputs, compare at negedge, advance memory and model
    task automatic tick(input logic r, input logic rv, input logic [31:0] ra,
                        input logic rdy, input logic irdy);
        logic        e_req;
        logic        e_ival;
        logic        rsp;
        logic        acc;
        logic        pop;
        logic [31:0] rdat;
        logic [31:0] ra_al;
        int          lat;
        int          due;
        ra_al = {ra[31:2], 2'b00};
        rsp   = 1'b0;
        rdat  = '0;
        if (!r && pend_due.size() > 0) begin
            if (pend_due[0] <= cyc) begin
                rsp  = 1'b1;
                rdat = mem_fn(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
        rst            = r;
        redirect_valid = rv;
        redirect_addr  = ra;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? rdat : $urandom;

        @(negedge clk);
        e_req  = !r && !rv && (m_fifo.size() + m_infl < DEPTH);
        e_ival = !r && (m_fifo.size() > 0);
        chk("imem_req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) chk("imem_req_addr", imem_req_addr, m_fetch);
        chk("inst_valid", 32'(inst_valid), 32'(e_ival));
        if (e_ival) begin
            chk("inst_pc", inst_pc, m_fifo[0][63:32]);
            chk("inst_data", inst_data, m_fifo[0][31:0]);
        end else if (r) begin
            chk("inst_pc_rst", inst_pc, 32'h0);
            chk("inst_data_rst", inst_data, 32'h0);
        end
        last_req_vld  = imem_req_valid;
        last_req_addr = imem_req_addr;
        last_ival     = inst_valid;
        last_ipc      = inst_pc;
        last_idat     = inst_data;

        // delivered stream: sequential pcs, data straight from memory
        if (!r && inst_valid && irdy) begin
            dlv_pc.push_back(inst_pc);
            dlv_dat.push_back(inst_data);
            dlv_cyc.push_back(cyc);
            chk("seq_pc", inst_pc, seq_expect);
            chk("seq_data", inst_data, mem_fn(inst_pc));
            seq_expect = seq_expect + 32'd4;
        end
        if (r) seq_expect = RST_PC;
        else if (rv) seq_expect = ra_al;

        // memory accepts whatever the DUT actually offers
        if (!r && imem_req_valid && rdy) begin
            acc_cnt++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
            last_due = due;
        end

        // reference model state after this edge
        acc = e_req && rdy;
        pop = e_ival && irdy;
        if (r) begin
            m_fifo.delete();
            m_infl   = 0;
            m_drop   = 0;
            m_fetch  = RST_PC;
            m_rsp_pc = RST_PC;
            pend_addr.delete();
            pend_due.delete();
            last_due = cyc;
        end else if (rv) begin
            m_fifo.delete();
            m_fetch  = ra_al;
            m_rsp_pc = ra_al;
            m_infl   = m_infl - int'(rsp);
            m_drop   = m_infl;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (rsp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    m_fifo.push_back({m_rsp_pc, rdat});
                    m_rsp_pc = m_rsp_pc + 32'd4;
                end
            end
            if (acc) m_fetch = m_fetch + 32'd4;
            m_infl = m_infl + int'(acc) - int'(rsp);
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int          mark;
        int          rel;
        int          acc0;
        logic [31:0] ra;
        logic [31:0] exp_seq[4];
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        m_fetch        = RST_PC;
        m_rsp_pc       = RST_PC;
        m_infl         = 0;
        m_drop         = 0;
        exp_seq        = '{32'h0, 32'h4, 32'h8, 32'hC};

        // reset, then streaming with 1-cycle memory
        lat_min = 1; lat_max = 1;
        repeat (3) tick(1, 0, '0, 1, 1);
        chk("rst_req_valid", 32'(last_req_vld), 32'h0);
        chk("rst_inst_valid", 32'(last_ival), 32'h0);
        mark = dlv_pc.size();
        rel  = cyc;
        repeat (12) tick(0, 0, '0, 1, 1);
        for (int i = 0; i < 4; i++) chk_dlv("stream_pc", mark + i, exp_seq[i]);
        if (dlv_cyc.size() > mark) chk("first_inst_cycle", 32'(dlv_cyc[mark]), 32'(rel + 2));

        // decode stalled: credit limit caps accepted requests
        repeat (2) tick(1, 0, '0, 1, 1);
        acc0 = acc_cnt;
        repeat (10) tick(0, 0, '0, 1, 0);
        chk("stall_accepts", 32'(acc_cnt - acc0), 32'd2);
        chk("stall_req_valid", 32'(last_req_vld), 32'h0);
        chk("stall_inst_valid", 32'(last_ival), 32'h1);
        chk("stall_inst_pc", last_ipc, 32'h0);
        chk("stall_inst_data", last_idat, mem_fn(32'h0));
        tick(0, 0, '0, 1, 1);
        tick(0, 0, '0, 1, 0);
        chk("unstall_req_valid", 32'(last_req_vld), 32'h1);
        chk("unstall_req_addr", last_req_addr, 32'h8);

        // redirect with two reads outstanding on a 3-cycle memory
        repeat (2) tick(1, 0, '0, 1, 1);
        lat_min = 3; lat_max = 3;
        repeat (2) tick(0, 0, '0, 1, 1);
        mark = dlv_pc.size();
        tick(0, 1, 32'h0000_0103, 1, 1);
        repeat (14) tick(0, 0, '0, 1, 1);
        chk_dlv("redirect_first_pc", mark, 32'h0000_0100);
        chk_dlv("redirect_second_pc", mark + 1, 32'h0000_0104);

        // redirect near the top of the address space wraps to zero
        lat_min = 1; lat_max = 1;
        mark = dlv_pc.size();
        tick(0, 1, 32'hFFFF_FFF8, 1, 1);
        repeat (12) tick(0, 0, '0, 1, 1);
        chk_dlv("wrap_pc0", mark, 32'hFFFF_FFF8);
        chk_dlv("wrap_pc1", mark + 1, 32'hFFFF_FFFC);
        chk_dlv("wrap_pc2", mark + 2, 32'h0000_0000);

        // reset while two reads are in flight
        repeat (2) tick(1, 0, '0, 1, 1);
        lat_min = 3; lat_max = 3;
        repeat (2) tick(0, 0, '0, 1, 0);
        tick(1, 0, '0, 1, 1);
        chk("midrst_req_valid", 32'(last_req_vld), 32'h0);
        chk("midrst_inst_valid", 32'(last_ival), 32'h0);
        chk("midrst_inst_pc", last_ipc, 32'h0);
        chk("midrst_inst_data", last_idat, 32'h0);
        tick(1, 0, '0, 1, 1);
        tick(0, 0, '0, 1, 1);
        chk("postrst_req_valid", 32'(last_req_vld), 32'h1);
        chk("postrst_req_addr", last_req_addr, RST_PC);
        mark = dlv_pc.size();
        repeat (10) tick(0, 0, '0, 1, 1);
        chk_dlv("postrst_first_pc", mark, RST_PC);

        // random soak: ready toggling, 1-3 cycle latency, occasional redirects
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
            tick(0, ($urandom_range(0, 31) == 0), ra,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end
        repeat (10) tick(0, 0, '0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
